// File: rtl/add_op_seq.sv
// Operand sequencer and result capture around an external ripple-carry adder.
// Operands load from the shared bus, settle for SETTLE cycles, then the sum and flags are held for a valid/ready consumer.
module add_op_seq #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 2
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             ld_a,
   input  logic             ld_b,
   input  logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_result,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [3:0] LAST = 4'(SETTLE - 1);

   state_t           state_reg, state_next;
   logic [3:0]       cnt_reg, cnt_next;
   logic [WIDTH-1:0] a_reg, b_reg, result_reg;
   logic             z_reg, n_reg, c_reg, v_reg;
   logic             z_next, n_next, c_next, v_next;
   logic             capture;

   assign capture = (state_reg == EXEC) && (cnt_reg == LAST);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = EXEC;
               cnt_next   = 4'd0;
            end
         end
         EXEC: begin
            cnt_next = cnt_reg + 4'd1;
            if (capture)
               state_next = DONE;
         end
         DONE: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Flags derive from the frozen operands; carry is recovered as wrap-around (R < A).
   always_comb begin
      z_next = (add_result == '0);
      n_next = add_result[WIDTH-1];
      c_next = (add_result < a_reg);
      v_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_result[WIDTH-1] != a_reg[WIDTH-1]);
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         a_reg <= '0;
         b_reg <= '0;
      end else if (state_reg == IDLE) begin
         if (ld_a)
            a_reg <= bus_in;
         if (ld_b)
            b_reg <= bus_in;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         result_reg <= '0;
         z_reg      <= 1'b0;
         n_reg      <= 1'b0;
         c_reg      <= 1'b0;
         v_reg      <= 1'b0;
      end else if (capture) begin
         result_reg <= add_result;
         z_reg      <= z_next;
         n_reg      <= n_next;
         c_reg      <= c_next;
         v_reg      <= v_next;
      end
   end

   assign busy      = (state_reg != IDLE);
   assign out_valid = (state_reg == DONE);
   assign add_a     = a_reg;
   assign add_b     = b_reg;
   assign result    = result_reg;
   assign flag_z    = z_reg;
   assign flag_n    = n_reg;
   assign flag_c    = c_reg;
   assign flag_v    = v_reg;

endmodule

// File: tb/tb_add_op_seq.sv
// Randomized self-checking bench for add_op_seq with an ideal adder attached.
// Expected sums, flags and latency come from plain integer arithmetic on the requested operands.
module tb_add_op_seq;
   localparam int WIDTH  = 8;
   localparam int SETTLE = 2;

   logic             clock = 1'b0;
   logic             clear;
   logic [WIDTH-1:0] bus_in;
   logic             ld_a, ld_b, start, out_ready;
   logic             busy, out_valid;
   logic [WIDTH-1:0] add_a, add_b, add_result, result;
   logic             flag_z, flag_n, flag_c, flag_v;

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   always #5 clock = ~clock;

   // Ideal adder standing in for RCAdder.
   assign add_result = add_a + add_b;

   add_op_seq #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clock(clock), .clear(clear), .bus_in(bus_in), .ld_a(ld_a), .ld_b(ld_b),
      .start(start), .busy(busy), .add_a(add_a), .add_b(add_b),
      .add_result(add_result), .result(result), .flag_z(flag_z), .flag_n(flag_n),
      .flag_c(flag_c), .flag_v(flag_v), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_result"}, 32'(result), 0);
      check({tag, "_flags"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, 0);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_ops"}, {16'd0, add_a, add_b}, 0);
   endtask

   // Clear asserted mid-cycle; outputs must drop without waiting for an edge.
   task automatic pulse_clear(input string tag);
      @(negedge clock);
      #2 clear = 1'b1;
      #1 check_all_zero(tag);
      @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic load_ops(input int a, input int b);
      @(negedge clock);
      ld_a = 1'b1; bus_in = 8'(a);
      @(negedge clock);
      ld_a = 1'b0; ld_b = 1'b1; bus_in = 8'(b);
      @(negedge clock);
      ld_b = 1'b0; bus_in = 8'($urandom);
      check("load_a", 32'(add_a), 32'(a));
      check("load_b", 32'(add_b), 32'(b));
   endtask

   // One add: start (optionally with same-cycle load of a==b), noise on loads/start while busy,
   // hold off the consumer for 'hold' cycles, then accept and confirm no spurious second result.
   task automatic run_add(input int a, input int b, input int hold, input bit same_cycle);
      int sum, sa, sb, ssum, lat, stray;
      logic [7:0] exp_r;
      logic exp_z, exp_n, exp_c, exp_v;
      sum   = a + b;
      exp_r = 8'(sum % 256);
      exp_c = (sum > 255);
      exp_z = (exp_r == 0);
      exp_n = (exp_r >= 128);
      sa    = (a >= 128) ? a - 256 : a;
      sb    = (b >= 128) ? b - 256 : b;
      ssum  = sa + sb;
      exp_v = (ssum > 127) || (ssum < -128);

      @(negedge clock);
      start = 1'b1;
      out_ready = (hold == 0);
      if (same_cycle) begin
         ld_a = 1'b1; ld_b = 1'b1; bus_in = 8'(a);
      end
      @(negedge clock);
      check("busy_rise", 32'(busy), 1);
      // start and loads held asserted throughout EXEC/DONE must be ignored.
      ld_a = 1'b1; ld_b = 1'b1; bus_in = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clock);
         lat++;
      end
      check("latency", 32'(lat), 32'(SETTLE));
      check("result", 32'(result), 32'(exp_r));
      check("flags", {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, exp_z, exp_n, exp_c, exp_v});
      for (int i = 0; i < hold; i++) begin
         bus_in = 8'd7;
         @(negedge clock);
         check("hold_valid", 32'(out_valid), 1);
         check("hold_result", 32'(result), 32'(exp_r));
         check("hold_ops", {16'd0, add_a, add_b}, {16'd0, 8'(a), 8'(b)});
      end
      out_ready = 1'b1;
      @(negedge clock);
      ld_a = 1'b0; ld_b = 1'b0; start = 1'b0;
      check("accept_valid", 32'(out_valid), 0);
      check("accept_busy", 32'(busy), 0);
      check("accept_ops", {16'd0, add_a, add_b}, {16'd0, 8'(a), 8'(b)});
      check("kept_result", 32'(result), 32'(exp_r));
      stray = 0;
      for (int i = 0; i < SETTLE + 3; i++) begin
         @(negedge clock);
         if (out_valid || busy) stray++;
      end
      check("no_second", 32'(stray), 0);
      $display("txn %0d a=%0d b=%0d result=%0d zncv=%b%b%b%b latency=%0d hold=%0d",
               txn, a, b, result, flag_z, flag_n, flag_c, flag_v, lat, hold);
      txn++;
   endtask

   initial begin
      int a, b, lat;
      clear = 1'b1; bus_in = '0; ld_a = 1'b0; ld_b = 1'b0; start = 1'b0; out_ready = 1'b0;
      #1 check_all_zero("reset");
      @(negedge clock);
      clear = 1'b0;

      load_ops(42, 58);   run_add(42, 58, 0, 1'b0);
      load_ops(200, 100); run_add(200, 100, 1, 1'b0);
      load_ops(100, 100); run_add(100, 100, 0, 1'b0);
      load_ops(128, 128); run_add(128, 128, 5, 1'b0);
      run_add(21, 21, 0, 1'b1);

      // Abort mid-EXEC.
      load_ops(105, 21);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("abort_busy", 32'(busy), 1);
      #2 clear = 1'b1;
      #1 check_all_zero("abort");
      @(negedge clock);
      clear = 1'b0;
      lat = 0;
      for (int i = 0; i < SETTLE + 3; i++) begin
         @(negedge clock);
         if (out_valid) lat++;
      end
      check("abort_no_valid", 32'(lat), 0);
      check("abort_result", 32'(result), 0);
      load_ops(105, 21);
      run_add(105, 21, 0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0)
            run_add(a, a, int'($urandom_range(0, 3)), 1'b1);
         else begin
            load_ops(a, b);
            run_add(a, b, int'($urandom_range(0, 3)), 1'b0);
         end
      end

      pulse_clear("final_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
